// File: rtl/seven_seg_pkg.sv
// Shared seven-segment pattern set, capture FSM states and the pattern-to-nibble decoder.
package seven_seg_pkg;

    // Segment order is {g,f,e,d,c,b,a}; bit0 = a.
    typedef enum logic [6:0] {
        BLANK = 7'h00,
        D0    = 7'h3F,
        D1    = 7'h06,
        D2    = 7'h5B,
        D3    = 7'h4F,
        D4    = 7'h66,
        D5    = 7'h6D,
        D6    = 7'h7D,
        D7    = 7'h07,
        D8    = 7'h7F,
        D9    = 7'h6F,
        DA    = 7'h77,
        DB    = 7'h7C,
        DC    = 7'h39,
        DD    = 7'h5E,
        DE    = 7'h79,
        DF    = 7'h71,
        DASH  = 7'h40,
        UNDER = 7'h08,
        LH    = 7'h76,
        LL    = 7'h38,
        LP    = 7'h73,
        LU    = 7'h3E
    } seven_seg_t;

    localparam logic [6:0] SEG_BLANK = BLANK;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLD
    } cap_state_t;

    typedef struct packed {
        logic       ok;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_hex(input logic [6:0] seg);
        seg_dec_t r;
        r = '{ok: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (seg)
            D0:        r.nibble = 4'h0;
            D1:        r.nibble = 4'h1;
            D2:        r.nibble = 4'h2;
            D3:        r.nibble = 4'h3;
            D4:        r.nibble = 4'h4;
            D5:        r.nibble = 4'h5;
            D6:        r.nibble = 4'h6;
            D7:        r.nibble = 4'h7;
            D8:        r.nibble = 4'h8;
            D9:        r.nibble = 4'h9;
            DA:        r.nibble = 4'hA;
            DB:        r.nibble = 4'hB;
            DC:        r.nibble = 4'hC;
            DD:        r.nibble = 4'hD;
            DE:        r.nibble = 4'hE;
            DF:        r.nibble = 4'hF;
            SEG_BLANK: begin
                r.ok    = 1'b0;
                r.blank = 1'b1;
            end
            default:   r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_stable_filter.sv
// Synchronizes the raw anode/segment bus, normalises polarity and strobes once when a pattern
// has been sampled STABLE_CYCLES times in a row.
module seven_seg_stable_filter #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [NUM_DIGITS-1:0] an_i,
    input  logic [6:0]            seg_i,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  changed,
    output logic                  stable
);
    localparam int W  = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);
    localparam logic [W-1:0]  POL     = {{NUM_DIGITS{AN_ACTIVE_LOW != 0}}, {7{SEG_ACTIVE_LOW != 0}}};

    logic [W-1:0]  meta;
    logic [W-1:0]  sync;
    logic [W-1:0]  s_norm;
    logic [W-1:0]  prev;
    logic [CW-1:0] cnt;

    assign s_norm  = sync ^ POL;
    assign an      = s_norm[W-1:7];
    assign seg     = s_norm[6:0];
    assign changed = (s_norm != prev);
    // Fires on the cycle whose edge takes cnt to STABLE_CYCLES, so the commit lands on that edge.
    assign stable  = run && !changed && (cnt == CNT_ARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
            cnt  <= '0;
        end else begin
            meta <= {an_i, seg_i};
            sync <= meta;
            prev <= s_norm;
            if (!run)
                cnt <= '0;
            else if (changed)
                cnt <= CW'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed seven-segment scan back into per-digit nibbles and
// reports complete frames plus a sticky protocol error.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    clr_err_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [6:0]              seg_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   hex_ok_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    frame_valid_o,
    output logic                    err_o
);
    cap_state_t            state;
    cap_state_t            state_next;
    logic                  run;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  changed;
    logic                  stable;
    seg_dec_t              dec;
    logic                  commit;
    logic                  err_set;
    logic [NUM_DIGITS-1:0] commit_mask;
    logic [NUM_DIGITS-1:0] seen;
    logic                  frame_done;

    assign run = en_i && (state != ST_IDLE);

    seven_seg_stable_filter #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .AN_ACTIVE_LOW (AN_ACTIVE_LOW),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .an_i   (an_i),
        .seg_i  (seg_i),
        .an     (an),
        .seg    (seg),
        .changed(changed),
        .stable (stable)
    );

    assign dec         = seg_to_hex(seg);
    assign commit_mask = commit ? an : '0;
    assign frame_done  = &seen;

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_i)
                    state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (!en_i) begin
                    state_next = ST_IDLE;
                end else if (stable) begin
                    if ($onehot(an)) begin
                        commit     = 1'b1;
                        err_set    = !dec.ok && !dec.blank;
                        state_next = ST_HOLD;
                    end else if (an != '0) begin
                        err_set    = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!en_i)
                    state_next = ST_IDLE;
                else if (changed)
                    state_next = ST_TRACK;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o      <= '0;
            hex_ok_o      <= '0;
            blank_o       <= '0;
            frame_valid_o <= 1'b0;
            err_o         <= 1'b0;
            seen          <= '0;
        end else begin
            frame_valid_o <= frame_done;
            // A commit on the frame-close edge belongs to the next frame.
            seen          <= (frame_done ? '0 : seen) | commit_mask;
            err_o         <= err_set | (err_o & ~clr_err_i);
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (commit_mask[i]) begin
                    digits_o[4*i +: 4] <= dec.nibble;
                    hex_ok_o[i]        <= dec.ok;
                    blank_o[i]         <= dec.blank;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed scoreboard bench: expected frames are queued as scans are issued and a
// monitor checks each frame_valid_o pulse against the queue head.
module tb_seven_seg_capture;
    localparam int ND = 4;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  hex_ok;
        logic [3:0]  blank;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic [ND-1:0] an_i = '1;
    logic [6:0]    seg_i = '0;
    logic [4*ND-1:0] digits_o;
    logic [ND-1:0] hex_ok_o;
    logic [ND-1:0] blank_o;
    logic          frame_valid_o;
    logic          err_o;

    frame_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     lat;
    int     glitch_bad;
    int     blank_bad;
    logic [23:0] snap;

    seven_seg_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (4),
        .AN_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .clr_err_i    (clr_err_i),
        .an_i         (an_i),
        .seg_i        (seg_i),
        .digits_o     (digits_o),
        .hex_ok_o     (hex_ok_o),
        .blank_o      (blank_o),
        .frame_valid_o(frame_valid_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // an_act is the active-high anode selection; the pins are active low.
    task automatic drive(input logic [ND-1:0] an_act, input logic [6:0] pat, input int n);
        @(negedge clk);
        an_i  = ~an_act;
        seg_i = pat;
        repeat (n) @(posedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_digits", digits_o, 0);
        check("rst_hex_ok", hex_ok_o, 0);
        check("rst_blank", blank_o, 0);
        check("rst_frame_valid", frame_valid_o, 0);
        check("rst_err", err_o, 0);
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (rst_n && frame_valid_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got digits 0x%0h expected no frame", digits_o);
            end else begin
                f = exp_q.pop_front();
                check("frame_digits", digits_o, f.digits);
                check("frame_hex_ok", hex_ok_o, f.hex_ok);
                check("frame_blank", blank_o, f.blank);
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        an_i  = ND'($urandom());
        seg_i = 7'($urandom());
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();

        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_digits", digits_o, 0);
        check("idle_hex_ok", hex_ok_o, 0);

        an_i  = '1;
        seg_i = '0;
        @(negedge clk);
        en_i = 1'b1;
        repeat (10) @(posedge clk);

        // Clean scan 3,0,A,F with latency measurement on the first digit.
        exp_q.push_back('{digits: 16'hFA03, hex_ok: 4'hF, blank: 4'h0});
        @(negedge clk);
        an_i  = ~4'b0001;
        seg_i = 7'h4F;
        lat   = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (digits_o[3:0] == 4'h3) begin
                lat = c;
                break;
            end
        end
        check("first_latency", lat, 6);
        repeat (2) @(posedge clk);
        drive(4'b0010, 7'h3F, 8);
        drive(4'b0100, 7'h77, 8);
        drive(4'b1000, 7'h71, 8);

        // Scan 5,1,C,E with a 3-cycle 0x7F glitch inside digit 1's dwell.
        exp_q.push_back('{digits: 16'hEC15, hex_ok: 4'hF, blank: 4'h0});
        drive(4'b0001, 7'h6D, 8);
        drive(4'b0010, 7'h06, 8);
        glitch_bad = 0;
        @(negedge clk);
        seg_i = 7'h7F;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (digits_o[7:4] != 4'h1) glitch_bad++;
        end
        @(negedge clk);
        seg_i = 7'h06;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (digits_o[7:4] != 4'h1) glitch_bad++;
        end
        check("glitch_digit1_bad_cycles", glitch_bad, 0);
        drive(4'b0100, 7'h39, 8);
        drive(4'b1000, 7'h79, 8);

        // Unknown pattern on anode 2.
        drive(4'b0100, 7'h40, 10);
        #1;
        check("dash_err", err_o, 1);
        check("dash_hex_ok2", hex_ok_o[2], 0);
        check("dash_nibble2", digits_o[11:8], 0);
        drive(4'b0000, 7'h00, 6);
        clr_pulse();
        check("dash_clr_err", err_o, 0);

        // Multi-hot anode.
        snap = {digits_o, hex_ok_o, blank_o};
        drive(4'b0011, 7'h06, 10);
        #1;
        check("multihot_err", err_o, 1);
        check("multihot_no_write", {digits_o, hex_ok_o, blank_o}, snap);
        drive(4'b0000, 7'h00, 6);
        clr_pulse();
        check("multihot_clr_err", err_o, 0);

        // Blank digit then a blanking interval.
        drive(4'b0001, 7'h00, 10);
        #1;
        check("blank0_blank", blank_o[0], 1);
        check("blank0_hex_ok", hex_ok_o[0], 0);
        check("blank0_nibble", digits_o[3:0], 0);
        snap = {digits_o, hex_ok_o, blank_o};
        blank_bad = 0;
        @(negedge clk);
        an_i = '1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if ({digits_o, hex_ok_o, blank_o} != snap) blank_bad++;
        end
        check("blanking_no_commit_cycles", blank_bad, 0);

        // Partial frame discarded by reset; next full scan starts on anode 3.
        drive(4'b0001, 7'h06, 8);
        drive(4'b0010, 7'h5B, 8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        an_i  = '1;
        seg_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{digits: 16'hB987, hex_ok: 4'hF, blank: 4'h0});
        drive(4'b1000, 7'h7C, 8);
        drive(4'b0001, 7'h07, 8);
        drive(4'b0010, 7'h7F, 8);
        drive(4'b0100, 7'h6F, 8);
        repeat (10) @(posedge clk);
        #1;
        check("pending_frames", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
